// File: rtl/bin2bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_pkg
// Purpose  : Shared types and elaboration-time helpers for the BCD converter.
// Revision : 1.0  initial release
// ============================================================================
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // 10^d as a 64-bit constant; d <= 10 keeps it well inside range.
    function automatic logic [63:0] pow10(input int d);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < d; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_pipe_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_pipe_ctrl_if
// Purpose  : Request/result bundle between a requester and the BCD converter.
// Revision : 1.0  initial release
// ============================================================================
interface bin2bcd_pipe_ctrl_if #(
    parameter int W = 20,
    parameter int D = 6
);
    logic           start;
    logic [W-1:0]   bin;
    logic           ready;
    logic           done_tick;
    logic [4*D-1:0] bcd;
    logic           neg;
    logic           ovf;
    logic [D-1:0]   blank;

    modport master (
        output start, bin,
        input  ready, done_tick, bcd, neg, ovf, blank
    );

    modport slave (
        input  start, bin,
        output ready, done_tick, bcd, neg, ovf, blank
    );
endinterface
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adj
// Purpose  : Double-dabble correction: add 3 (mod 16) to a digit above 4.
// Revision : 1.0  initial release
// ============================================================================
module bcd_digit_adj (
    input  logic [3:0] dig_i,
    output logic [3:0] dig_o
);
    assign dig_o = (dig_i > 4'd4) ? (dig_i + 4'd3) : dig_i;
endmodule
`default_nettype wire

// File: rtl/bin2bcd_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_pipe_ctrl
// Purpose  : Sequential shift-and-add-3 binary to packed BCD converter.
// Revision : 1.0  initial release
// ============================================================================
module bin2bcd_pipe_ctrl
    import bin2bcd_pkg::*;
#(
    parameter int W         = 20,
    parameter int D         = 6,
    parameter int SIGNED_EN = 0
) (
    input  logic                clk,
    input  logic                rst,
    bin2bcd_pipe_ctrl_if.slave  bus
);

    localparam int          CW  = clog2(W + 1);
    localparam logic [63:0] P10 = pow10(D);

    state_t          state_q, state_d;
    logic [W-1:0]    mag_q, mag_d;
    logic [4*D-1:0]  dig_q, dig_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            ovf_q, ovf_d;
    logic [D-1:0]    blank_q, blank_d;

    logic            accept;
    logic            in_neg;
    logic [W-1:0]    in_mag;
    logic            in_ovf;
    logic [4*D-1:0]  adj;
    logic [4*D-1:0]  shift_dig;
    logic [D-1:0]    shift_blank;
    logic            hi_zero;

    assign accept = (state_q == ST_IDLE) && bus.start;
    assign in_neg = (SIGNED_EN != 0) && bus.bin[W-1];
    // W-bit negation maps -2^(W-1) onto itself, which read unsigned is the magnitude.
    assign in_mag = in_neg ? ((~bus.bin) + W'(1)) : bus.bin;
    assign in_ovf = ({{(64-W){1'b0}}, in_mag} >= P10);

    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_digit
            bcd_digit_adj u_adj (
                .dig_i (dig_q[4*gi +: 4]),
                .dig_o (adj[4*gi +: 4])
            );
        end
    endgenerate

    // Carry out of the top digit falls off the end of the shift.
    assign shift_dig = {adj[4*D-2:0], mag_q[W-1]};

    always_comb begin
        shift_blank = '0;
        hi_zero     = 1'b1;
        for (int i = D - 1; i >= 1; i--) begin
            hi_zero        = hi_zero && (shift_dig[4*i +: 4] == 4'd0);
            shift_blank[i] = hi_zero;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE:  state_d = bus.start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_d = (cnt_q == CW'(1)) ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.ready     = (state_q == ST_IDLE);
        bus.done_tick = (state_q == ST_DONE);
        bus.bcd       = dig_q;
        bus.neg       = neg_q;
        bus.ovf       = ovf_q;
        bus.blank     = blank_q;
    end

    always_comb begin
        mag_d   = mag_q;
        dig_d   = dig_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
        blank_d = blank_q;
        if (accept) begin
            mag_d = in_mag;
            dig_d = '0;
            cnt_d = CW'(W);
            neg_d = in_neg;
            ovf_d = in_ovf;
        end else if (state_q == ST_SHIFT) begin
            mag_d = {mag_q[W-2:0], 1'b0};
            dig_d = shift_dig;
            cnt_d = cnt_q - CW'(1);
            // Capture blank on the last shift so it is valid alongside done_tick.
            if (cnt_q == CW'(1)) begin
                blank_d = shift_blank;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_q   <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
            blank_q <= '0;
        end else begin
            mag_q   <= mag_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
            blank_q <= blank_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_pipe_ctrl
// Purpose  : Scoreboard bench for an unsigned 20b/6d and a signed 8b/3d converter.
// Revision : 1.0  initial release
// ============================================================================
module tb_bin2bcd_pipe_ctrl;

    typedef struct {
        logic [23:0] bcd;
        logic        neg;
        logic        ovf;
        logic [5:0]  blank;
        longint      acc;
        bit          strm;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst;
    longint cyc = 0;
    int     n_checks = 0;
    int     n_pass = 0;
    exp_t   qa[$];
    exp_t   qb[$];

    bin2bcd_pipe_ctrl_if #(.W(20), .D(6)) bus_a ();
    bin2bcd_pipe_ctrl_if #(.W(8),  .D(3)) bus_b ();

    bin2bcd_pipe_ctrl #(.W(20), .D(6), .SIGNED_EN(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    bin2bcd_pipe_ctrl #(.W(8), .D(3), .SIGNED_EN(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] model_bcd(input longint v, input int d);
        logic [23:0] r;
        longint      x;
        r = '0;
        x = v;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [5:0] model_blank(input logic [23:0] b, input int d);
        logic [5:0] r;
        bit         z;
        r = '0;
        z = 1'b1;
        for (int i = d - 1; i >= 1; i--) begin
            z    = z && (b[4*i +: 4] == 4'd0);
            r[i] = z;
        end
        return r;
    endfunction

    // Monitors: pop and compare on every done_tick.
    longint last_done_a = 0;
    bit     last_strm_a = 1'b0;
    always @(negedge clk) begin
        if (bus_a.done_tick) begin
            chk("a_done_expected", longint'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                exp_t e;
                e = qa.pop_front();
                chk("a_bcd",     bus_a.bcd,   e.bcd);
                chk("a_neg",     bus_a.neg,   e.neg);
                chk("a_ovf",     bus_a.ovf,   e.ovf);
                chk("a_blank",   bus_a.blank, e.blank);
                chk("a_latency", cyc - e.acc, 20);
                if (e.strm && last_strm_a) begin
                    chk("a_interval", cyc - last_done_a, 22);
                end
                last_strm_a = e.strm;
            end
            last_done_a = cyc;
        end
    end

    always @(negedge clk) begin
        if (bus_b.done_tick) begin
            chk("b_done_expected", longint'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                exp_t e;
                e = qb.pop_front();
                chk("b_bcd",     bus_b.bcd,   e.bcd);
                chk("b_neg",     bus_b.neg,   e.neg);
                chk("b_ovf",     bus_b.ovf,   e.ovf);
                chk("b_blank",   bus_b.blank, e.blank);
                chk("b_latency", cyc - e.acc, 8);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue_a(input logic [19:0] b, input logic [23:0] eb, input logic eovf,
                           input logic [5:0] ebl, input bit push);
        int t;
        t = 0;
        while (!bus_a.ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("a_ready_timeout", bus_a.ready, 1);
        bus_a.bin   = b;
        bus_a.start = 1'b1;
        if (push) qa.push_back('{eb, 1'b0, eovf, ebl, cyc + 1, 1'b0});
        @(negedge clk);
        bus_a.start = 1'b0;
    endtask

    task automatic issue_b(input logic [7:0] b, input logic [11:0] eb, input logic eneg,
                           input logic [2:0] ebl);
        int t;
        t = 0;
        while (!bus_b.ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("b_ready_timeout", bus_b.ready, 1);
        bus_b.bin   = b;
        bus_b.start = 1'b1;
        qb.push_back('{{12'h0, eb}, eneg, 1'b0, {3'b0, ebl}, cyc + 1, 1'b0});
        @(negedge clk);
        bus_b.start = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  t;
        bit  bad;
        rst         = 1'b1;
        bus_a.start = 1'b0;
        bus_a.bin   = '0;
        bus_b.start = 1'b0;
        bus_b.bin   = '0;
        repeat (3) @(negedge clk);
        bus_a.start = 1'b1;
        bus_a.bin   = 20'd77;
        @(negedge clk);
        chk("rst_ready",  bus_a.ready,     1);
        chk("rst_done",   bus_a.done_tick, 0);
        chk("rst_bcd",    bus_a.bcd,       0);
        chk("rst_neg",    bus_a.neg,       0);
        chk("rst_ovf",    bus_a.ovf,       0);
        chk("rst_blank",  bus_a.blank,     0);
        chk("rst_b_ready", bus_b.ready,    1);
        chk("rst_b_bcd",  bus_b.bcd,       0);
        bus_a.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Signed instance: most negative, -1, most positive, zero.
        issue_b(8'h80, 12'h128, 1'b1, 3'b000);
        issue_b(8'hFF, 12'h001, 1'b1, 3'b110);
        issue_b(8'h7F, 12'h127, 1'b0, 3'b000);
        issue_b(8'h00, 12'h000, 1'b0, 3'b110);
        issue_b(8'hF6, 12'h010, 1'b1, 3'b100);

        // Unsigned instance: top in-range value, overflow, small value.
        issue_a(20'd999999,  24'h999999, 1'b0, 6'b000000, 1'b1);
        issue_a(20'd1000000, 24'h000000, 1'b1, 6'b111110, 1'b1);
        issue_a(20'd42,      24'h000042, 1'b0, 6'b111100, 1'b1);

        // start pulsed mid-conversion must be ignored.
        issue_a(20'd555555,  24'h555555, 1'b0, 6'b000000, 1'b1);
        repeat (3) @(negedge clk);
        bus_a.start = 1'b1;
        bus_a.bin   = 20'd123;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_a.bin   = 20'hABCDE;
        t   = 0;
        bad = 1'b0;
        while (!bus_a.done_tick && t < 40) begin
            if (bus_a.ready) bad = 1'b1;
            @(negedge clk);
            t++;
        end
        chk("a_busy_ready_low", bad, 0);
        chk("a_busy_done_seen", longint'(t < 40), 1);
        chk("a_busy_ready_in_done", bus_a.ready, 0);
        @(negedge clk);
        chk("a_ready_after_done", bus_a.ready, 1);

        // Abort mid-shift with an overflowing operand.
        issue_a(20'hFFFFF, 24'h0, 1'b1, 6'b0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", bus_a.ready,     1);
        chk("abort_done",  bus_a.done_tick, 0);
        chk("abort_bcd",   bus_a.bcd,       0);
        chk("abort_ovf",   bus_a.ovf,       0);
        chk("abort_neg",   bus_a.neg,       0);
        chk("abort_blank", bus_a.blank,     0);
        repeat (30) @(negedge clk);
        issue_a(20'd12345, 24'h012345, 1'b0, 6'b100000, 1'b1);

        // Back-to-back conversions with start held high.
        bus_a.start = 1'b1;
        for (int n = 0; n <= 1000; n++) begin
            logic [23:0] eb;
            t = 0;
            while (!bus_a.ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (t >= 100) chk("a_stream_ready_timeout", bus_a.ready, 1);
            bus_a.bin = 20'(n);
            eb = model_bcd(longint'(n), 6);
            qa.push_back('{eb, 1'b0, 1'b0, model_blank(eb, 6), cyc + 1, 1'b1});
            @(negedge clk);
        end
        bus_a.start = 1'b0;

        t = 0;
        while ((qa.size() > 0 || qb.size() > 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (30) @(negedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
